button_debouncer: RTL and testbench



---
 rtl/tp1_pkg.sv | 18 +
 rtl/debounce_bit.sv | 93 +++++++++
 rtl/button_debouncer.sv | 43 ++++
 tb/tb_button_debouncer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tp1_pkg.sv
// Shared types and constants for the push-button debouncer.
// Holds the per-bit FSM encoding and the debounce cycle counts.
package tp1_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_e;

  // 10 ms at 100 MHz.
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;

  // Short window for simulation.
  localparam int unsigned DEBOUNCE_CYCLES_SIM = 4;

endpackage

// File: rtl/debounce_bit.sv
// Single-button debouncer: 2-flop synchronizer, FSM, hold counter.
// Ports: clock, reset (async high), raw in; level, pulse out (registered).
module debounce_bit
  import tp1_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic             s;

  assign s = sync_q[1];

  always_comb begin
    sync_d  = {sync_q[0], raw};
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HIGH;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
    level_d = (state_d == HIGH) ||
              (state_d == WAIT_LOW);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces N raw buttons into levels and rising-edge pulses.
// Ports: clock, reset (async high), buttons_raw in; buttons_level, buttons_pulse out.
// Option: BUTTON_ONEHOT_GUARD_EN drops pulses while >1 level bit is set.
module button_debouncer
  import tp1_pkg::*;
#(
  parameter int unsigned N_BUTTONS       = 3,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] buttons_raw,
  output logic [N_BUTTONS-1:0] buttons_level,
  output logic [N_BUTTONS-1:0] buttons_pulse
);

  logic [N_BUTTONS-1:0] level_w;
  logic [N_BUTTONS-1:0] pulse_w;

  for (genvar i = 0; i < int'(N_BUTTONS); i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clock(clock),
      .reset(reset),
      .raw  (buttons_raw[i]),
      .level(level_w[i]),
      .pulse(pulse_w[i])
    );
  end

  assign buttons_level = level_w;

`ifdef BUTTON_ONEHOT_GUARD_EN
  // level_w is registered on the same edge as pulse_w, so it is
  // the next-state level the pulse was produced with.
  assign buttons_pulse =
    ($countones(level_w) > 1) ? '0 : pulse_w;
`else
  assign buttons_pulse = pulse_w;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer with a short window.
// Directed plan plus randomized bounce against a run-length model.
module tb_button_debouncer;
  import tp1_pkg::*;

  localparam int N = 3;
  localparam int D = DEBOUNCE_CYCLES_SIM;

`ifdef BUTTON_ONEHOT_GUARD_EN
  localparam logic [N-1:0] SIM_PULSE = 3'b000;
`else
  localparam logic [N-1:0] SIM_PULSE = 3'b110;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] buttons_raw = '0;
  logic [N-1:0] buttons_level;
  logic [N-1:0] buttons_pulse;

  always #5 clock = ~clock;

  button_debouncer #(
    .N_BUTTONS      (N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .buttons_raw  (buttons_raw),
    .buttons_level(buttons_level),
    .buttons_pulse(buttons_pulse)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag,
                          input logic [N-1:0] got,
                          input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b",
               tag, got, exp);
    end
  endtask

  // Reference: s is raw delayed two edges; a bit flips after
  // D+1 consecutive edges of s disagreeing with the level.
  logic [N-1:0] m_hist[$];
  logic [N-1:0] m_level;
  logic [N-1:0] m_pulse;
  int           m_run[N];

  task automatic model_clear();
    logic [N-1:0] z;
    z = '0;
    m_hist.delete();
    m_hist.push_back(z);
    m_hist.push_back(z);
    m_level = '0;
    m_pulse = '0;
    for (int b = 0; b < N; b++) m_run[b] = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] raw);
    logic [N-1:0] s;
    s = m_hist.pop_front();
    m_hist.push_back(raw);
    m_pulse = '0;
    for (int b = 0; b < N; b++) begin
      if (s[b] != m_level[b]) begin
        m_run[b]++;
        if (m_run[b] == D + 1) begin
          m_level[b] = ~m_level[b];
          m_run[b]   = 0;
          if (m_level[b]) m_pulse[b] = 1'b1;
        end
      end else begin
        m_run[b] = 0;
      end
    end
`ifdef BUTTON_ONEHOT_GUARD_EN
    if ($countones(m_level) > 1) m_pulse = '0;
`endif
  endtask

  task automatic step(input logic [N-1:0] raw);
    buttons_raw = raw;
    @(posedge clock);
    model_edge(raw);
    #1;
    check_eq("level", buttons_level, m_level);
    check_eq("pulse", buttons_pulse, m_pulse);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    #1;
    check_eq("rst_async_level", buttons_level, '0);
    check_eq("rst_async_pulse", buttons_pulse, '0);
    @(posedge clock);
    #1;
    check_eq("rst_hold_level", buttons_level, '0);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold[N];
    logic [N-1:0] rv;

    // Reset then idle.
    do_reset();
    repeat (20) step(3'b000);
    check_eq("idle_level", buttons_level, 3'b000);

    // Clean press.
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step(3'b100);
      if (k == 6)
        check_eq("press_e6_level", buttons_level, 3'b000);
      if (k == 7) begin
        check_eq("press_e7_level", buttons_level, 3'b100);
        check_eq("press_e7_pulse", buttons_pulse, 3'b100);
      end
      if (k == 8) begin
        check_eq("press_e8_level", buttons_level, 3'b100);
        check_eq("press_e8_pulse", buttons_pulse, 3'b000);
      end
    end
    repeat (10) step(3'b100);

    // Bounce on bit 1, then stable.
    do_reset();
    step(3'b010);
    step(3'b000);
    step(3'b010);
    step(3'b000);
    for (int k = 1; k <= 8; k++) begin
      step(3'b010);
      if (k == 6)
        check_eq("bounce_e6_level", buttons_level, 3'b000);
      if (k == 7) begin
        check_eq("bounce_e7_level", buttons_level, 3'b010);
        check_eq("bounce_e7_pulse", buttons_pulse, 3'b010);
      end
    end

    // Release.
    do_reset();
    repeat (10) step(3'b001);
    for (int k = 1; k <= 8; k++) begin
      step(3'b000);
      if (k == 6)
        check_eq("rel_e6_level", buttons_level, 3'b001);
      if (k == 7) begin
        check_eq("rel_e7_level", buttons_level, 3'b000);
        check_eq("rel_e7_pulse", buttons_pulse, 3'b000);
      end
    end

    // Reset mid-count, asserted across edge 5.
    do_reset();
    for (int k = 1; k <= 4; k++) step(3'b100);
    check_eq("mid_e4_pulse", buttons_pulse, 3'b000);
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step(3'b100);
      if (k == 6)
        check_eq("mid_p6_level", buttons_level, 3'b000);
      if (k == 7) begin
        check_eq("mid_p7_level", buttons_level, 3'b100);
        check_eq("mid_p7_pulse", buttons_pulse, 3'b100);
      end
      if (k == 8)
        check_eq("mid_p8_pulse", buttons_pulse, 3'b000);
    end

    // Simultaneous press.
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step(3'b110);
      if (k == 7) begin
        check_eq("sim_level", buttons_level, 3'b110);
        check_eq("sim_pulse", buttons_pulse, SIM_PULSE);
      end
    end

    // Random bounce with variable hold lengths.
    do_reset();
    rv = '0;
    for (int b = 0; b < N; b++) hold[b] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < N; b++) begin
        if (hold[b] == 0) begin
          rv[b]   = 1'($urandom_range(0, 1));
          hold[b] = $urandom_range(1, 2 * D + 4);
        end
        hold[b]--;
      end
      if ($urandom_range(0, 399) == 0) begin
        buttons_raw = rv;
        do_reset();
      end
      step(rv);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
